// File: rtl/addsub_pkg.sv
// Shared constants and flag bundle for the pipelined adder/subtractor.
// Default width and depth match the ALU datapath build.
package addsub_pkg;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;

  typedef struct packed {
    logic carry_out;
    logic overflow;
    logic zero;
  } flags_t;

endpackage

// File: rtl/ripple_chunk.sv
// Combinational CHUNK-bit ripple of full-adder cells.
// Also exposes the carry into the MSB for signed-overflow detection.
module ripple_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub: one CHUNK ripple per stage, carry registered between.
// ADDSUB_SATURATE_EN adds satMode, clamping signed overflow per beat.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             subMode,
`ifdef ADDSUB_SATURATE_EN
  input  logic             satMode,
`endif
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;

  logic adv;

  logic [STAGES-1:0]            valid_q, valid_d, src_v;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, src_a;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d, src_b;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d, src_s;
  logic [STAGES-1:0]            carry_q, carry_d, src_c;
  logic [STAGES-1:0][CHUNK-1:0] ch_a, ch_b, ch_s;
  logic [STAGES-1:0]            ch_co, ch_cm;
`ifdef ADDSUB_SATURATE_EN
  logic [STAGES-1:0]            sat_q, sat_d, src_sat;
`endif
  flags_t flags_q, flags_d;

  assign adv     = ~valid_q[L] | outReady;
  assign inReady = adv;

  // Stage 0 sees the raw operands; later stages see the previous register.
  always_comb begin
    src_v    = '0;
    src_a    = '0;
    src_b    = '0;
    src_s    = '0;
    src_c    = '0;
    src_v[0] = inValid;
    src_a[0] = operandA;
    src_b[0] = (subMode == SUB_OP) ? ~operandB : operandB;
    src_c[0] = subMode;
`ifdef ADDSUB_SATURATE_EN
    src_sat    = '0;
    src_sat[0] = satMode;
`endif
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = valid_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = sum_q[k-1];
      src_c[k] = carry_q[k-1];
`ifdef ADDSUB_SATURATE_EN
      src_sat[k] = sat_q[k-1];
`endif
    end
    ch_a = '0;
    ch_b = '0;
    for (int k = 0; k < STAGES; k++) begin
      ch_a[k] = src_a[k][k*CHUNK +: CHUNK];
      ch_b[k] = src_b[k][k*CHUNK +: CHUNK];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ripple_chunk #(.CHUNK(CHUNK)) u_rc (
      .a    (ch_a[k]),
      .b    (ch_b[k]),
      .cin  (src_c[k]),
      .sum  (ch_s[k]),
      .cout (ch_co[k]),
      .cmsb (ch_cm[k])
    );
  end

  always_comb begin
    logic ovf;
    valid_d = src_v;
    a_d     = src_a;
    b_d     = src_b;
    sum_d   = src_s;
    carry_d = ch_co;
`ifdef ADDSUB_SATURATE_EN
    sat_d   = src_sat;
`endif
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k][k*CHUNK +: CHUNK] = ch_s[k];
    end
    ovf = ch_co[L] ^ ch_cm[L];
`ifdef ADDSUB_SATURATE_EN
    if (src_sat[L] && ovf) begin
      sum_d[L] = {src_a[L][WIDTH-1],
                  {(WIDTH-1){~src_a[L][WIDTH-1]}}};
    end
`endif
    flags_d.carry_out = ch_co[L];
    flags_d.overflow  = ovf;
    flags_d.zero      = (sum_d[L] == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      flags_q <= '0;
`ifdef ADDSUB_SATURATE_EN
      sat_q   <= '0;
`endif
    end else if (adv) begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      flags_q <= flags_d;
`ifdef ADDSUB_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign outValid = valid_q[L];
  assign result   = sum_q[L];
  assign carryOut = flags_q.carry_out;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub at WIDTH=8, STAGES=2.
// Saturation vectors are included when ADDSUB_SATURATE_EN is defined.
module tb_pipelined_addsub;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       inValid;
  logic       inReady;
  logic [7:0] operandA;
  logic [7:0] operandB;
  logic       subMode;
`ifdef ADDSUB_SATURATE_EN
  logic       satMode;
`endif
  logic       outValid;
  logic       outReady;
  logic [7:0] result;
  logic       carryOut;
  logic       overflow;
  logic       zero;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .inValid  (inValid),
    .inReady  (inReady),
    .operandA (operandA),
    .operandB (operandB),
    .subMode  (subMode),
`ifdef ADDSUB_SATURATE_EN
    .satMode  (satMode),
`endif
    .outValid (outValid),
    .outReady (outReady),
    .result   (result),
    .carryOut (carryOut),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       sat;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] beat_a [16];
  logic [7:0] beat_b [16];
  logic       beat_s [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference: {result, carry, overflow, zero} via a 9-bit sum.
  function automatic logic [10:0] model(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic sub,
                                        input logic sat);
    logic [7:0] bb;
    logic [8:0] s;
    logic [7:0] r;
    logic       v;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
    r  = s[7:0];
    v  = (a[7] == bb[7]) && (r[7] != a[7]);
    if (sat && v) r = a[7] ? 8'h80 : 8'h7F;
    return {r, s[8], v, (r == 8'h00)};
  endfunction

  task automatic apply_vec(input int idx, input vec_t v);
    inValid  = 1'b1;
    operandA = v.a;
    operandB = v.b;
    subMode  = v.sub;
`ifdef ADDSUB_SATURATE_EN
    satMode  = v.sat;
`endif
    @(posedge CLK); #1;
    inValid  = 1'b0;
    operandA = 8'($urandom);
    operandB = 8'($urandom);
    @(posedge CLK);
    @(negedge CLK);
    chk($sformatf("vec%0d_valid", idx), 32'(outValid), 32'd1);
    chk($sformatf("vec%0d_res", idx), 32'(result), 32'(v.res));
    chk($sformatf("vec%0d_carry", idx), 32'(carryOut), 32'(v.c));
    chk($sformatf("vec%0d_ovf", idx), 32'(overflow), 32'(v.v));
    chk($sformatf("vec%0d_zero", idx), 32'(zero), 32'(v.z));
    @(posedge CLK); #1;
  endtask

  // Streams beats with outReady held low for the first `stall` cycles.
  task automatic run_stream(input int nbeats, input int stall,
                            input int ncyc);
    logic [10:0] q[$];
    logic [10:0] exp;
    int sent = 0;
    int got = 0;
    logic acc;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      outReady = (cyc >= stall);
      if (sent < nbeats) begin
        inValid  = 1'b1;
        operandA = beat_a[sent];
        operandB = beat_b[sent];
        subMode  = beat_s[sent];
      end else begin
        inValid  = 1'b0;
        operandA = 8'($urandom);
        operandB = 8'($urandom);
      end
      @(negedge CLK);
      if (stall == 0) begin
        chk($sformatf("stream_valid_c%0d", cyc), 32'(outValid),
            32'(cyc >= 2 && cyc < 2 + nbeats));
      end else if (cyc >= 2 && cyc < stall) begin
        chk($sformatf("stall_inready_c%0d", cyc), 32'(inReady), 32'd0);
        chk($sformatf("stall_valid_c%0d", cyc), 32'(outValid), 32'd1);
        exp = (q.size() != 0) ? q[0] : 11'h7FF;
        chk($sformatf("stall_hold_c%0d", cyc),
            32'({result, carryOut, overflow, zero}), 32'(exp));
      end
      acc = inValid && inReady;
      if (acc) q.push_back(model(operandA, operandB, subMode, 1'b0));
      if (outValid && outReady) begin
        exp = (q.size() != 0) ? q.pop_front() : 11'h7FF;
        chk($sformatf("stream_beat%0d", got),
            32'({result, carryOut, overflow, zero}), 32'(exp));
        got++;
      end
      @(posedge CLK); #1;
      if (acc) sent++;
    end
    chk("stream_count", 32'(got), 32'(nbeats));
    chk("stream_drain", 32'(q.size()), 32'd0);
    inValid  = 1'b0;
    outReady = 1'b1;
  endtask

  vec_t tbl [8];
`ifdef ADDSUB_SATURATE_EN
  vec_t sat_tbl [2];
`endif

  initial begin
    tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
`ifdef ADDSUB_SATURATE_EN
    sat_tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    sat_tbl[1] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
    satMode = 1'b0;
`endif
    RESET    = 1'b1;
    inValid  = 1'b0;
    operandA = 8'h00;
    operandB = 8'h00;
    subMode  = 1'b0;
    outReady = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carryOut), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ready", 32'(inReady), 32'd1);
    @(posedge CLK); #1;

    for (int i = 0; i < 8; i++) apply_vec(i, tbl[i]);

    for (int i = 0; i < 16; i++) begin
      beat_a[i] = 8'($urandom);
      beat_b[i] = 8'($urandom);
      beat_s[i] = 1'($urandom);
    end
    run_stream(10, 0, 14);

    beat_a[0] = 8'h11; beat_b[0] = 8'h22; beat_s[0] = 1'b0;
    beat_a[1] = 8'h40; beat_b[1] = 8'h50; beat_s[1] = 1'b1;
    beat_a[2] = 8'hF0; beat_b[2] = 8'h20; beat_s[2] = 1'b0;
    run_stream(3, 4, 10);

    outReady = 1'b1;
    inValid  = 1'b1;
    operandA = 8'h01; operandB = 8'h02; subMode = 1'b0;
    @(posedge CLK); #1;
    operandA = 8'h03; operandB = 8'h04;
    @(posedge CLK); #1;
    RESET   = 1'b1;
    inValid = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_valid", 32'(outValid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_ready", 32'(inReady), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("midrst_idle%0d", i), 32'(outValid), 32'd0);
    end
    @(posedge CLK); #1;
    apply_vec(100, '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0});

`ifdef ADDSUB_SATURATE_EN
    for (int i = 0; i < 2; i++) apply_vec(200 + i, sat_tbl[i]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
